// File: rtl/blit_pkg.sv
// blit_pkg: definitions shared by the blitter write stage.
//   BLIT_ADDR_W  - byte address width of the pixel stream and memory port
//   blit_word_t  - one buffered word write (word address, data, byte enables)
//   lane_decode  - byte-lane select ([1:0] of a byte address) to one-hot enable
package blit_pkg;

    localparam int unsigned BLIT_ADDR_W = 26;

    typedef struct packed {
        logic [23:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } blit_word_t;

    function automatic logic [3:0] lane_decode(input logic [1:0] lane);
        logic [3:0] en;
        en       = '0;
        en[lane] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/blit_write_fifo.sv
// blit_write_fifo: synchronous FIFO of blit_word_t entries.
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   push, din     - write an entry (ignored when full)
//   pop           - drop the head entry (ignored when empty)
//   head          - current head entry
//   empty, full   - occupancy flags
//   count         - number of stored entries
module blit_write_fifo
    import blit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  blit_word_t             din,
    input  logic                   pop,
    output blit_word_t             head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    blit_word_t    mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the parent masks the head while empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/blit_write.sv
// blit_write: final write stage of the blitter pipeline.
// Merges per-pixel byte writes to the same 32-bit word (when
// BLIT_WRITE_COMBINE_EN is defined), buffers word writes in a FIFO and issues
// them to memory under a request/acknowledge handshake.
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   p4_write/address/wdata  - byte write stream from the colour stage
//   p4_flush                - end-of-blit pulse, forces out a partial word
//   p4_stall                - registered back-pressure to the pipeline
//   mem_request/address/wdata/byte_en, mem_ack - memory word-write port
//   busy                    - registered: work still buffered or pending
//   overflow                - sticky: a push was dropped on a full FIFO
// Macro BLIT_WRITE_COMBINE_EN: enables the combine register; without it every
// byte write becomes its own word write with the byte replicated on all lanes.
module blit_write
    import blit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   p4_write,
    input  logic [BLIT_ADDR_W-1:0] p4_address,
    input  logic [7:0]             p4_wdata,
    input  logic                   p4_flush,
    output logic                   p4_stall,
    output logic                   mem_request,
    output logic [BLIT_ADDR_W-1:0] mem_address,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_byte_en,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - 2);

    logic          push, pop;
    blit_word_t    push_word, head;
    logic          empty, full;
    logic [CW-1:0] count;
    logic [3:0]    lane_en;
    logic          flush_q, flush_d;
    logic          stall_q, stall_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;

    assign lane_en = lane_decode(p4_address[1:0]);

`ifdef BLIT_WRITE_COMBINE_EN
    logic        cv_q, cv_d;
    logic [23:0] ca_q, ca_d;
    logic [31:0] cd_q, cd_d;
    logic [3:0]  cbe_q, cbe_d;
    logic        write_push;

    always_comb begin
        cv_d       = cv_q;
        ca_d       = ca_q;
        cd_d       = cd_q;
        cbe_d      = cbe_q;
        push       = 1'b0;
        push_word  = '0;
        write_push = 1'b0;
        flush_d    = flush_q;
        if (p4_write) begin
            if (cv_q && (p4_address[25:2] == ca_q)) begin
                cd_d[{p4_address[1:0], 3'b000} +: 8] = p4_wdata;
                cbe_d = cbe_q | lane_en;
                if (&cbe_d) begin
                    push      = 1'b1;
                    push_word = '{waddr: ca_q, data: cd_d, be: cbe_d};
                    cv_d      = 1'b0;
                end
            end else begin
                if (cv_q) begin
                    push      = 1'b1;
                    push_word = '{waddr: ca_q, data: cd_q, be: cbe_q};
                end
                cv_d  = 1'b1;
                ca_d  = p4_address[25:2];
                cd_d  = {4{p4_wdata}};
                cbe_d = lane_en;
            end
        end
        write_push = push;
        // A pending flush acts on the post-write register contents, but
        // yields to a write-triggered push so only one push happens per cycle.
        if (flush_q && !write_push) begin
            if (cv_d) begin
                push      = 1'b1;
                push_word = '{waddr: ca_d, data: cd_d, be: cbe_d};
                cv_d      = 1'b0;
            end
            flush_d = 1'b0;
        end
        flush_d = flush_d | p4_flush;
        busy_d  = cv_q | flush_q | ~empty;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cv_q  <= 1'b0;
            ca_q  <= '0;
            cd_q  <= '0;
            cbe_q <= '0;
        end else begin
            cv_q  <= cv_d;
            ca_q  <= ca_d;
            cd_q  <= cd_d;
            cbe_q <= cbe_d;
        end
    end
`else
    always_comb begin
        push      = p4_write;
        push_word = '{waddr: p4_address[25:2], data: {4{p4_wdata}}, be: lane_en};
        flush_d   = p4_flush | (flush_q & push);
        busy_d    = flush_q | ~empty;
    end
`endif

    always_comb begin
        pop        = ~empty & mem_ack;
        stall_d    = (count >= STALL_LEVEL);
        overflow_d = overflow_q | (push & full);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            flush_q    <= flush_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    blit_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .head  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign mem_request = ~empty;
    assign mem_address = empty ? '0 : {head.waddr, 2'b00};
    assign mem_wdata   = empty ? '0 : head.data;
    assign mem_byte_en = empty ? '0 : head.be;
    assign p4_stall    = stall_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_blit_write.sv
module tb_blit_write;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        p4_write;
    logic [25:0] p4_address;
    logic [7:0]  p4_wdata;
    logic        p4_flush;
    logic        p4_stall;
    logic        mem_request;
    logic [25:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    blit_write #(.FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .p4_write    (p4_write),
        .p4_address  (p4_address),
        .p4_wdata    (p4_wdata),
        .p4_flush    (p4_flush),
        .p4_stall    (p4_stall),
        .mem_request (mem_request),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the pending combined word as a byte array, the
    // buffered word writes as a queue, plus the registered status flags.
    typedef struct {
        logic [23:0] wa;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_word_t;

    bit          m_cv;
    logic [23:0] m_wa;
    logic [7:0]  m_bytes [4];
    bit          m_en [4];
    exp_word_t   m_q [$];
    bit          m_flush, m_stall, m_busy, m_ovf;

    function automatic exp_word_t pack_pending();
        exp_word_t w;
        w.wa = m_wa;
        w.data = '0;
        w.be = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_en[i]) begin
                w.data[8*i +: 8] = m_bytes[i];
                w.be[i] = 1'b1;
            end
        end
        return w;
    endfunction

    task automatic model_clear();
        m_cv = 0; m_wa = '0; m_flush = 0; m_stall = 0; m_busy = 0; m_ovf = 0;
        for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_bytes[i] = '0; end
        m_q.delete();
    endtask

    // Effect of one rising edge given the current inputs.
    task automatic model_edge();
        int cnt, lane;
        bit have, nstall, nbusy;
        exp_word_t w;
        logic [23:0] wa;
        cnt    = m_q.size();
        nstall = (cnt >= DEPTH - 2);
        nbusy  = m_cv || m_flush || (cnt != 0);
        have   = 0;
        w      = '{default: '0};
        lane   = int'(p4_address[1:0]);
        wa     = p4_address[25:2];
`ifdef BLIT_WRITE_COMBINE_EN
        if (p4_write) begin
            if (m_cv && wa == m_wa) begin
                m_bytes[lane] = p4_wdata;
                m_en[lane] = 1;
                if (m_en[0] && m_en[1] && m_en[2] && m_en[3]) begin
                    w = pack_pending(); have = 1; m_cv = 0;
                end
            end else begin
                if (m_cv) begin w = pack_pending(); have = 1; end
                m_cv = 1; m_wa = wa;
                for (int i = 0; i < 4; i++) m_en[i] = 0;
                m_en[lane] = 1; m_bytes[lane] = p4_wdata;
            end
        end
        if (m_flush && !have) begin
            if (m_cv) begin w = pack_pending(); have = 1; m_cv = 0; end
            m_flush = 0;
        end
`else
        if (p4_write) begin
            w.wa = wa; w.data = {4{p4_wdata}}; w.be = 4'b0001 << lane; have = 1;
        end
        if (m_flush && !have) m_flush = 0;
`endif
        if (p4_flush) m_flush = 1;
        if (cnt != 0 && mem_ack) void'(m_q.pop_front());
        if (have) begin
            if (cnt == DEPTH) m_ovf = 1;
            else m_q.push_back(w);
        end
        m_stall = nstall;
        m_busy  = nbusy;
    endtask

    task automatic cycle();
        if (reset) model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        p4_write = 0; p4_address = '0; p4_wdata = '0; p4_flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_ack = 0;
        reset = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
    endtask

    task automatic wr(input logic [25:0] a, input logic [7:0] d);
        p4_write = 1; p4_address = a; p4_wdata = d;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_request, mem_address, mem_wdata, mem_byte_en, p4_stall, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_values: got req=%b addr=%h data=%h be=%h stall=%b busy=%b ovf=%b, need all 0",
                     mem_request, mem_address, mem_wdata, mem_byte_en, p4_stall, busy, overflow);
        end
    endtask

`ifdef BLIT_WRITE_COMBINE_EN
    task automatic test_full_word();
        logic [7:0] d;
        mem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            d = 8'((i + 1) * 8'h11);
            wr(26'h100 + 26'(i), d);
            cycle();
            if (i == 2) begin
                checks++;
                if (mem_request !== 1'b0) begin
                    errors++; $display("FAIL fw_early_req: got %b need 0", mem_request);
                end
            end
        end
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 26'h100 || mem_wdata !== 32'h44332211 || mem_byte_en !== 4'hF) begin
            errors++;
            $display("FAIL fw_word: got req=%b addr=%h data=%h be=%h need 1/100/44332211/f",
                     mem_request, mem_address, mem_wdata, mem_byte_en);
        end
        idle_inputs();
        cycle();
        checks++;
        if (mem_request !== 1'b0) begin errors++; $display("FAIL fw_pop: req got %b need 0", mem_request); end
    endtask

    task automatic test_partial_flush();
        mem_ack = 0;
        wr(26'h201, 8'hAA); cycle();
        wr(26'h304, 8'hBB); cycle();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 26'h200 || mem_byte_en !== 4'h2 || mem_wdata[15:8] !== 8'hAA) begin
            errors++;
            $display("FAIL pf_first: got req=%b addr=%h be=%h data=%h need 1/200/2/..AA..",
                     mem_request, mem_address, mem_byte_en, mem_wdata);
        end
        idle_inputs(); p4_flush = 1; mem_ack = 1; cycle();
        p4_flush = 0; cycle();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 26'h304 || mem_byte_en !== 4'h1 || mem_wdata[7:0] !== 8'hBB) begin
            errors++;
            $display("FAIL pf_second: got req=%b addr=%h be=%h data=%h need 1/304/1/....BB",
                     mem_request, mem_address, mem_byte_en, mem_wdata);
        end
        cycle();
        checks++;
        if (mem_request !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL pf_after_ack: got req=%b busy=%b need 0/1", mem_request, busy);
        end
        cycle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pf_busy_fall: got %b need 0", busy); end
    endtask

    task automatic test_same_lane();
        mem_ack = 1;
        wr(26'h400, 8'h01); cycle();
        wr(26'h400, 8'h02); cycle();
        idle_inputs(); p4_flush = 1; cycle();
        p4_flush = 0; cycle();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 26'h400 || mem_byte_en !== 4'h1 || mem_wdata[7:0] !== 8'h02) begin
            errors++;
            $display("FAIL sl_word: got req=%b addr=%h be=%h data=%h need 1/400/1/....02",
                     mem_request, mem_address, mem_byte_en, mem_wdata);
        end
        cycle();
        checks++;
        if (mem_request !== 1'b0) begin errors++; $display("FAIL sl_single: req got %b need 0", mem_request); end
    endtask
`else
    task automatic test_nocombine();
        mem_ack = 1;
        wr(26'h101, 8'h5A); cycle();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 26'h100 || mem_byte_en !== 4'h2 || mem_wdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL nc_first: got req=%b addr=%h be=%h data=%h need 1/100/2/5a5a5a5a",
                     mem_request, mem_address, mem_byte_en, mem_wdata);
        end
        wr(26'h102, 8'hC3); cycle();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 26'h100 || mem_byte_en !== 4'h4 || mem_wdata !== 32'hC3C3C3C3) begin
            errors++;
            $display("FAIL nc_second: got req=%b addr=%h be=%h data=%h need 1/100/4/c3c3c3c3",
                     mem_request, mem_address, mem_byte_en, mem_wdata);
        end
        idle_inputs(); cycle();
        checks++;
        if (mem_request !== 1'b0) begin errors++; $display("FAIL nc_drain: req got %b need 0", mem_request); end
    endtask
`endif

    task automatic test_stall_overflow();
        bit es, eo;
        mem_ack = 0;
        for (int i = 0; i <= 10; i++) begin
            wr(26'(32'h10 * i), 8'(i));
            cycle();
`ifdef BLIT_WRITE_COMBINE_EN
            es = (i >= 7); eo = (i >= 9);
`else
            es = (i >= 6); eo = (i >= 8);
`endif
            checks++;
            if (p4_stall !== es || overflow !== eo) begin
                errors++;
                $display("FAIL so_write%0d: got stall=%b ovf=%b need %b/%b", i, p4_stall, overflow, es, eo);
            end
        end
        idle_inputs();
        mem_ack = 1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (mem_request !== 1'b1 || mem_address !== 26'(32'h10 * k) || mem_wdata[7:0] !== 8'(k)) begin
                errors++;
                $display("FAIL so_drain%0d: got req=%b addr=%h data=%h need 1/%h/..%h",
                         k, mem_request, mem_address, mem_wdata, 26'(32'h10 * k), 8'(k));
            end
            cycle();
        end
        checks++;
        if (mem_request !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL so_end: got req=%b ovf=%b need 0/1", mem_request, overflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_ack = 0;
`ifdef BLIT_WRITE_COMBINE_EN
        for (int i = 0; i < 4; i++) begin wr(26'(32'h10 * i), 8'(i + 1)); cycle(); end
`else
        for (int i = 0; i < 3; i++) begin wr(26'(32'h10 * i), 8'(i + 1)); cycle(); end
`endif
        idle_inputs();
        checks++;
        if (mem_request !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL ar_queued: got req=%b busy=%b need 1/1", mem_request, busy);
        end
        #2;
        reset = 0;
        model_clear();
        #1;
        checks++;
        if ({mem_request, mem_address, mem_wdata, mem_byte_en, p4_stall, busy, overflow} !== '0) begin
            errors++;
            $display("FAIL ar_async: got req=%b addr=%h data=%h be=%h stall=%b busy=%b ovf=%b, need all 0",
                     mem_request, mem_address, mem_wdata, mem_byte_en, p4_stall, busy, overflow);
        end
        @(posedge clock); #1;
        reset = 1;
        mem_ack = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (mem_request !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL ar_stale%0d: got req=%b busy=%b need 0/0", i, mem_request, busy);
            end
        end
    endtask

    task automatic test_random();
        bit        ereq;
        exp_word_t h;
        logic [31:0] mask;
        int n;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            idle_inputs();
            if ($urandom_range(99) < 60 && (!p4_stall || $urandom_range(99) < 3)) begin
                if ($urandom_range(99) < 20) wr(26'($urandom), 8'($urandom));
                else wr(26'h1000 + 26'($urandom_range(3) * 4 + $urandom_range(3)), 8'($urandom));
            end
            p4_flush = ($urandom_range(49) == 0);
            mem_ack  = ($urandom_range(99) < 65);
            cycle();
            ereq = (m_q.size() != 0);
            h = ereq ? m_q[0] : '{default: '0};
            mask = '0;
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{h.be[i]}};
            checks++;
            if (mem_request !== ereq || mem_address !== {h.wa, 2'b00} || mem_byte_en !== h.be ||
                (mem_wdata & mask) !== (h.data & mask) || (!ereq && mem_wdata !== 32'h0)) begin
                errors++;
                $display("FAIL rnd_port@%0d: got req=%b addr=%h be=%h data=%h need %b/%h/%h/%h",
                         c, mem_request, mem_address, mem_byte_en, mem_wdata, ereq, {h.wa, 2'b00}, h.be, h.data);
            end
            checks++;
            if (p4_stall !== m_stall || busy !== m_busy || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_flags@%0d: got stall=%b busy=%b ovf=%b need %b/%b/%b",
                         c, p4_stall, busy, overflow, m_stall, m_busy, m_ovf);
            end
        end
        idle_inputs();
        p4_flush = 1; mem_ack = 1;
        cycle();
        p4_flush = 0;
        n = 0;
        while (busy !== 1'b0 && n < 64) begin cycle(); n++; end
        checks++;
        if (busy !== 1'b0 || mem_request !== 1'b0 || m_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: got busy=%b req=%b model_left=%0d need 0/0/0 within 64 cycles",
                     busy, mem_request, m_q.size());
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        mem_ack = 0;
        model_clear();
        #2;
        test_reset();
`ifdef BLIT_WRITE_COMBINE_EN
        test_full_word();
        test_partial_flush();
        test_same_lane();
`else
        test_nocombine();
`endif
        test_stall_overflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
